// File: rtl/z80_bus_cycle_gen.sv
// rtl/z80_bus_cycle_gen.sv - Z80 external bus-cycle sequencer with waits, refresh and wait timeout
//
// Runs one queued request at a time as a Z80 bus cycle (T1, T2, TW..., T3, optional T4 refresh).
// Every output is registered and is computed from the next state, so it matches the state the
// sequencer is in during that clock.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_type/req_addr/req_wdata captured at accept
//   rsp_valid/rsp_rdata/rsp_err one-clock completion pulse, read data, timeout-abort flag
//   wait_n, din                 external wait (active low) and bus read data
//   A, dout                     bus address and write data
//   m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n   Z80 strobes, active low
module z80_bus_cycle_gen #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 1,
    parameter int INTA_WAIT = 2,
    parameter int T2_WRITE  = 1,
    parameter int REFRESH   = 1,
    parameter int WAIT_TMO  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              wait_n,
    input  logic [DATA_W-1:0] din,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] dout,
    output logic              m1_n,
    output logic              mreq_n,
    output logic              iorq_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              rfsh_n
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

    localparam logic [2:0] TY_FETCH = 3'd0, TY_MRD = 3'd1, TY_MWR = 3'd2,
                           TY_IORD  = 3'd3, TY_IOWR = 3'd4, TY_INTA = 3'd5;

    state_t            state, state_nx;
    logic [2:0]        typ_q, typ_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx, a_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx, data_q, data_nx, dout_nx, rdata_nx;
    logic [2:0]        auto_cnt, auto_nx;
    logic [15:0]       tmo_cnt, tmo_nx;
    logic [6:0]        r_q, r_nx;
    logic              ready_nx, valid_nx, err_nx;
    logic              m1_nx, mreq_nx, iorq_nx, rd_nx, wr_nx, rfsh_nx;

    // Fetch and int-ack are the M1 cycles that may carry a refresh tail.
    function automatic logic is_m1(input logic [2:0] t);
        return (t == TY_FETCH) || (t == TY_INTA);
    endfunction

    function automatic logic [2:0] wait_of(input logic [2:0] t);
        case (t)
            TY_FETCH, TY_MRD, TY_MWR: return 3'(MEM_WAIT);
            TY_IORD, TY_IOWR:         return 3'(IO_WAIT);
            TY_INTA:                  return 3'(INTA_WAIT);
            default:                  return 3'd0;
        endcase
    endfunction

    logic cur_rfsh, cur_null;
    logic nx_rt, nx_mem, nx_io, nx_wr, nx_rd, nx_rfsh;

    assign cur_rfsh = (REFRESH != 0) && is_m1(typ_q);
    assign cur_null = (typ_q > TY_INTA);
    assign nx_rt    = is_m1(typ_nx);
    assign nx_mem   = (typ_nx == TY_FETCH) || (typ_nx == TY_MRD) || (typ_nx == TY_MWR);
    assign nx_io    = (typ_nx == TY_IORD) || (typ_nx == TY_IOWR);
    assign nx_wr    = (typ_nx == TY_MWR) || (typ_nx == TY_IOWR);
    assign nx_rd    = (typ_nx == TY_FETCH) || (typ_nx == TY_MRD) || (typ_nx == TY_IORD);
    assign nx_rfsh  = (REFRESH != 0) && nx_rt;

    // Next state, cycle bookkeeping and response generation.
    always_comb begin
        state_nx = state;
        typ_nx   = typ_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        data_nx  = data_q;
        auto_nx  = auto_cnt;
        tmo_nx   = tmo_cnt;
        r_nx     = r_q;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        rdata_nx = rsp_rdata;
        case (state)
            S_IDLE: state_nx = S_IDLE;
            S_T1: begin
                state_nx = S_T2;
                auto_nx  = wait_of(typ_q);
                tmo_nx   = '0;
            end
            S_T2, S_TW: begin
                if (cur_null) begin
                    state_nx = S_T3;
                end else if (auto_cnt != 3'd0) begin
                    // Auto waits never count toward the timeout and break a wait_n streak.
                    state_nx = S_TW;
                    auto_nx  = auto_cnt - 3'd1;
                    tmo_nx   = '0;
                end else if (!wait_n) begin
                    if ((WAIT_TMO != 0) && (state == S_TW) && (tmo_cnt == 16'(WAIT_TMO - 1))) begin
                        state_nx = S_IDLE;
                        valid_nx = 1'b1;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = S_TW;
                        tmo_nx   = (state == S_TW) ? tmo_cnt + 16'd1 : 16'd0;
                    end
                end else begin
                    state_nx = S_T3;
                    if (is_m1(typ_q)) data_nx = din;
                end
            end
            S_T3: begin
                if (cur_rfsh) begin
                    state_nx = S_T4;
                end else begin
                    state_nx = S_IDLE;
                    valid_nx = 1'b1;
                    if (is_m1(typ_q))                               rdata_nx = data_q;
                    else if ((typ_q == TY_MRD) || (typ_q == TY_IORD)) rdata_nx = din;
                    else if (cur_null)                              rdata_nx = '0;
                end
            end
            S_T4: begin
                state_nx = S_IDLE;
                valid_nx = 1'b1;
                rdata_nx = data_q;
                r_nx     = r_q + 7'd1;
            end
            default: state_nx = S_IDLE;
        endcase
        // req_ready is only high in IDLE or the final state, so this overrides a completion.
        if (req_valid && req_ready) begin
            state_nx = S_T1;
            typ_nx   = req_type;
            addr_nx  = req_addr;
            wdata_nx = req_wdata;
        end
    end

    // Bus outputs for the state being entered.
    always_comb begin
        ready_nx = 1'b0;
        m1_nx    = 1'b1;
        mreq_nx  = 1'b1;
        iorq_nx  = 1'b1;
        rd_nx    = 1'b1;
        wr_nx    = 1'b1;
        rfsh_nx  = 1'b1;
        a_nx     = A;
        dout_nx  = dout;
        case (state_nx)
            S_IDLE: ready_nx = 1'b1;
            S_T1: begin
                a_nx  = addr_nx;
                m1_nx = !nx_rt;
                if (nx_wr) dout_nx = wdata_nx;
            end
            S_T2, S_TW: begin
                a_nx    = addr_nx;
                m1_nx   = !nx_rt;
                mreq_nx = !nx_mem;
                iorq_nx = !(nx_io || (typ_nx == TY_INTA));
                rd_nx   = !nx_rd;
                wr_nx   = !(nx_wr && (T2_WRITE != 0));
            end
            S_T3: begin
                ready_nx = !nx_rfsh;
                if (nx_rfsh) begin
                    a_nx    = ADDR_W'(r_nx);
                    rfsh_nx = 1'b0;
                    mreq_nx = 1'b0;
                end else begin
                    a_nx    = addr_nx;
                    mreq_nx = !((typ_nx == TY_MRD) || (typ_nx == TY_MWR));
                    iorq_nx = !nx_io;
                    rd_nx   = !((typ_nx == TY_MRD) || (typ_nx == TY_IORD));
                    wr_nx   = !nx_wr;
                end
            end
            S_T4: begin
                ready_nx = 1'b1;
                a_nx     = ADDR_W'(r_nx);
                rfsh_nx  = 1'b0;
            end
            default: ready_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            typ_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            auto_cnt  <= '0;
            tmo_cnt   <= '0;
            r_q       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            A         <= '0;
            dout      <= '0;
            m1_n      <= 1'b1;
            mreq_n    <= 1'b1;
            iorq_n    <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            rfsh_n    <= 1'b1;
        end else begin
            state     <= state_nx;
            typ_q     <= typ_nx;
            addr_q    <= addr_nx;
            wdata_q   <= wdata_nx;
            data_q    <= data_nx;
            auto_cnt  <= auto_nx;
            tmo_cnt   <= tmo_nx;
            r_q       <= r_nx;
            req_ready <= ready_nx;
            rsp_valid <= valid_nx;
            rsp_err   <= err_nx;
            rsp_rdata <= rdata_nx;
            A         <= a_nx;
            dout      <= dout_nx;
            m1_n      <= m1_nx;
            mreq_n    <= mreq_nx;
            iorq_n    <= iorq_nx;
            rd_n      <= rd_nx;
            wr_n      <= wr_nx;
            rfsh_n    <= rfsh_nx;
        end
    end

endmodule

// File: tb/tb_z80_bus_cycle_gen.sv
// tb/tb_z80_bus_cycle_gen.sv - self-checking bench for z80_bus_cycle_gen
module tb_z80_bus_cycle_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_type;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        wait_n;
    logic [7:0]  din;
    logic [15:0] A;
    logic [7:0]  dout;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;

    always #5 clk = ~clk;

    z80_bus_cycle_gen #(
        .ADDR_W(16), .DATA_W(8), .MEM_WAIT(0), .IO_WAIT(1), .INTA_WAIT(2),
        .T2_WRITE(1), .REFRESH(1), .WAIT_TMO(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wait_n(wait_n), .din(din), .A(A), .dout(dout),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {err, rdata}.
    logic [8:0] exp_q[$];
    logic [7:0] model_rdata;
    logic [6:0] model_r;

    // Observations from the most recent cycle run by do_cycle.
    int          ob_cycles, ob_m1, ob_mreq, ob_iorq, ob_rd, ob_wr, ob_rfsh, ob_iorq_m1;
    logic [15:0] ob_a_t1, ob_a_rfsh;
    logic        ob_first_m1, ob_dout_bad, ob_last_quiet;

    always @(negedge clk) begin : scoreboard
        logic [8:0] e;
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    errors++;
                    $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                             rsp_err, rsp_rdata, e[8], e[7:0]);
                end
            end
        end
    end

    // Presents one request at a negedge where req_ready is high and follows it to the next
    // ready state; wait_n is low while the state index is in [ws, ws+wc).
    task automatic do_cycle(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                            input logic [7:0] dv, input int ws, input int wc,
                            input logic [7:0] er, input logic ee);
        int  idx;
        bit  done;
        ob_cycles = 0; ob_m1 = 0; ob_mreq = 0; ob_iorq = 0; ob_rd = 0; ob_wr = 0;
        ob_rfsh = 0; ob_iorq_m1 = 0; ob_a_t1 = '0; ob_a_rfsh = 16'hFFFF;
        ob_first_m1 = 1'b1; ob_dout_bad = 1'b0; ob_last_quiet = 1'b0;
        for (int k = 0; k < 20 && req_ready !== 1'b1; k++) @(negedge clk);
        exp_q.push_back({ee, er});
        req_type = t; req_addr = a; req_wdata = wd; din = dv; wait_n = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        done = 1'b0;
        idx = 1;
        while (idx < 40 && !done) begin
            ob_cycles = idx;
            if (idx == 1) begin
                ob_a_t1 = A;
                ob_first_m1 = m1_n;
            end
            if (!m1_n)   ob_m1++;
            if (!mreq_n) ob_mreq++;
            if (!iorq_n) ob_iorq++;
            if (!rd_n)   ob_rd++;
            if (!wr_n)   ob_wr++;
            if (!iorq_n && !m1_n) ob_iorq_m1++;
            if (!rfsh_n) begin
                ob_rfsh++;
                ob_a_rfsh = A;
            end
            if (!wr_n && dout !== wd) ob_dout_bad = 1'b1;
            wait_n = (idx >= ws && idx < ws + wc) ? 1'b0 : 1'b1;
            if (req_ready === 1'b1) begin
                ob_last_quiet = m1_n & mreq_n & iorq_n & rd_n & wr_n & rfsh_n;
                done = 1'b1;
            end else begin
                @(negedge clk);
                idx++;
            end
        end
        wait_n = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL cycle_bound: type %0d never returned to ready within %0d clocks", t, idx);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_type = '0; req_addr = '0; req_wdata = '0;
        wait_n = 1'b1; din = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} !== 6'b111111) begin
            errors++; $display("FAIL reset_strobes: got %b, required 111111", {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n});
        end
        checks++;
        if (A !== 16'h0000 || dout !== 8'h00) begin
            errors++; $display("FAIL reset_bus: got A=%h dout=%h, required 0000/00", A, dout);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h, required 0/0/00", rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
        reset = 1'b0;
        model_r = '0;
        model_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_mem_read();
        do_cycle(3'd1, 16'h4000, 8'h00, 8'hA5, 0, 0, 8'hA5, 1'b0);
        model_rdata = 8'hA5;
        checks++;
        if (ob_cycles !== 3) begin errors++; $display("FAIL mrd_cycles: got %0d, required 3", ob_cycles); end
        checks++;
        if (ob_rd !== 2 || ob_mreq !== 2) begin
            errors++; $display("FAIL mrd_strobes: got rd=%0d mreq=%0d, required 2/2", ob_rd, ob_mreq);
        end
        checks++;
        if (ob_m1 !== 0 || ob_iorq !== 0 || ob_wr !== 0 || ob_rfsh !== 0) begin
            errors++; $display("FAIL mrd_other: got m1=%0d iorq=%0d wr=%0d rfsh=%0d, required 0", ob_m1, ob_iorq, ob_wr, ob_rfsh);
        end
        checks++;
        if (ob_a_t1 !== 16'h4000) begin errors++; $display("FAIL mrd_addr: got %h, required 4000", ob_a_t1); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fetch_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            d = 8'h10 + 8'(i);
            do_cycle(3'd0, 16'h0000, 8'h00, d, 2, 1, d, 1'b0);
            model_rdata = d;
            checks++;
            if (ob_cycles !== 5 || ob_first_m1 !== 1'b0) begin
                errors++; $display("FAIL fetch%0d_timing: got %0d clks first_m1=%b, required 5 clks first_m1=0", i, ob_cycles, ob_first_m1);
            end
            checks++;
            if (ob_m1 !== 3 || ob_mreq !== 3 || ob_rd !== 2 || ob_rfsh !== 2) begin
                errors++; $display("FAIL fetch%0d_strobes: got m1=%0d mreq=%0d rd=%0d rfsh=%0d, required 3/3/2/2", i, ob_m1, ob_mreq, ob_rd, ob_rfsh);
            end
            checks++;
            if (ob_a_rfsh !== {9'd0, model_r}) begin
                errors++; $display("FAIL fetch%0d_rfsh_addr: got %h, required %h", i, ob_a_rfsh, {9'd0, model_r});
            end
            model_r = model_r + 7'd1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_io_write();
        do_cycle(3'd4, 16'h7F00, 8'h55, 8'h00, 3, 2, model_rdata, 1'b0);
        checks++;
        if (ob_cycles !== 6 || ob_iorq !== 5 || ob_wr !== 5) begin
            errors++; $display("FAIL iowr_strobes: got clks=%0d iorq=%0d wr=%0d, required 6/5/5", ob_cycles, ob_iorq, ob_wr);
        end
        checks++;
        if (ob_mreq !== 0 || ob_rd !== 0 || ob_dout_bad !== 1'b0 || dout !== 8'h55) begin
            errors++; $display("FAIL iowr_bus: got mreq=%0d rd=%0d dout=%h, required 0/0/55", ob_mreq, ob_rd, dout);
        end
        checks++;
        if (ob_a_t1 !== 16'h7F00) begin errors++; $display("FAIL iowr_addr: got %h, required 7F00", ob_a_t1); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_int_ack();
        do_cycle(3'd5, 16'h0038, 8'h00, 8'hFF, 0, 0, 8'hFF, 1'b0);
        model_rdata = 8'hFF;
        checks++;
        if (ob_cycles !== 6 || ob_m1 !== 4 || ob_iorq !== 3 || ob_iorq_m1 !== 3) begin
            errors++; $display("FAIL inta_strobes: got clks=%0d m1=%0d iorq=%0d iorq_m1=%0d, required 6/4/3/3", ob_cycles, ob_m1, ob_iorq, ob_iorq_m1);
        end
        checks++;
        if (ob_mreq !== 1 || ob_rfsh !== 2 || ob_rd !== 0 || ob_a_rfsh !== {9'd0, model_r}) begin
            errors++; $display("FAIL inta_refresh: got mreq=%0d rfsh=%0d rd=%0d A=%h, required 1/2/0/%h", ob_mreq, ob_rfsh, ob_rd, ob_a_rfsh, {9'd0, model_r});
        end
        model_r = model_r + 7'd1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        do_cycle(3'd1, 16'h1234, 8'h00, 8'h99, 2, 100, model_rdata, 1'b1);
        checks++;
        if (ob_cycles !== 7 || ob_mreq !== 5 || ob_rd !== 5) begin
            errors++; $display("FAIL tmo_length: got clks=%0d mreq=%0d rd=%0d, required 7/5/5", ob_cycles, ob_mreq, ob_rd);
        end
        checks++;
        if (ob_last_quiet !== 1'b1) begin errors++; $display("FAIL tmo_strobes_high: got %b, required 1", ob_last_quiet); end
        repeat (2) @(negedge clk);
        do_cycle(3'd0, 16'h2000, 8'h00, 8'h3C, 0, 0, 8'h3C, 1'b0);
        model_rdata = 8'h3C;
        checks++;
        if (ob_cycles !== 4 || ob_m1 !== 2 || ob_a_rfsh !== {9'd0, model_r}) begin
            errors++; $display("FAIL tmo_next_fetch: got clks=%0d m1=%0d rfshA=%h, required 4/2/%h", ob_cycles, ob_m1, ob_a_rfsh, {9'd0, model_r});
        end
        model_r = model_r + 7'd1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_null();
        do_cycle(3'd6, 16'h0ABC, 8'h77, 8'hEE, 2, 3, 8'h00, 1'b0);
        model_rdata = 8'h00;
        checks++;
        if (ob_cycles !== 3) begin errors++; $display("FAIL null_cycles: got %0d, required 3", ob_cycles); end
        checks++;
        if (ob_m1 + ob_mreq + ob_iorq + ob_rd + ob_wr + ob_rfsh !== 0) begin
            errors++; $display("FAIL null_strobes: got %0d strobe-low samples, required 0", ob_m1 + ob_mreq + ob_iorq + ob_rd + ob_wr + ob_rfsh);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_tw();
        for (int k = 0; k < 20 && req_ready !== 1'b1; k++) @(negedge clk);
        req_type = 3'd3; req_addr = 16'h0022; din = 8'h81; wait_n = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (iorq_n !== 1'b0 || rd_n !== 1'b0) begin
            errors++; $display("FAIL rst_tw_active: got iorq_n=%b rd_n=%b, required 0/0", iorq_n, rd_n);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} !== 6'b111111 || A !== 16'h0000 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_tw_outputs: got strobes=%b A=%h ready=%b, required 111111/0000/1", {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}, A, req_ready);
        end
        reset = 1'b0;
        model_r = '0;
        model_rdata = '0;
        repeat (3) @(negedge clk);
        do_cycle(3'd0, 16'h0100, 8'h00, 8'h5A, 0, 0, 8'h5A, 1'b0);
        model_rdata = 8'h5A;
        checks++;
        if (ob_cycles !== 4 || ob_first_m1 !== 1'b0 || ob_a_rfsh !== 16'h0000) begin
            errors++; $display("FAIL rst_tw_next: got clks=%0d first_m1=%b rfshA=%h, required 4/0/0000", ob_cycles, ob_first_m1, ob_a_rfsh);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_fetch_back_to_back();
        test_io_write();
        test_int_ack();
        test_timeout();
        test_null();
        test_reset_in_tw();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rsp_missing: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
